// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one variable-latency memory port between fetch and memory stage
module mem_port_arbiter #(
   parameter int AW           = 32,
   parameter int DW           = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 255
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [DW-1:0] if_rdata,
   output logic          if_ready,
   output logic          if_busy,
   input  logic          mm_req,
   input  logic          mm_we,
   input  logic [AW-1:0] mm_addr,
   input  logic [DW-1:0] mm_wdata,
   output logic [DW-1:0] mm_rdata,
   output logic          mm_ready,
   output logic          mm_busy,
   output logic          err,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_ack,
   input  logic [DW-1:0] mem_rdata
);

   localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
   localparam logic [TW-1:0] TMO_LAST   = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state;
   state_t        state_next;
   logic          start;
   logic          pick_mm;
   logic          ack_done;
   logic          tmo_done;
   logic          grant_mm;
   logic [SW-1:0] starve_cnt;
   logic [TW-1:0] tmo_cnt;
   logic [DW-1:0] done_data;

   assign if_busy   = if_req & ~if_ready;
   assign mm_busy   = mm_req & ~mm_ready;
   assign done_data = tmo_done ? '0 : mem_rdata;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      start      = 1'b0;
      pick_mm    = 1'b0;
      ack_done   = 1'b0;
      tmo_done   = 1'b0;
      case (state)
         IDLE: begin
            if (if_req || mm_req) begin
               start      = 1'b1;
               // fetch takes a conflict once it has lost STARVE_LIMIT in a row
               pick_mm    = mm_req && !(if_req && (starve_cnt >= STARVE_MAX));
               state_next = BUSY;
            end
         end
         BUSY: begin
            if (mem_ack) begin
               ack_done   = 1'b1;
               state_next = DONE;
            end else if ((TIMEOUT != 0) && (tmo_cnt == TMO_LAST)) begin
               tmo_done   = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         grant_mm   <= 1'b0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         if_rdata   <= '0;
         mm_rdata   <= '0;
         if_ready   <= 1'b0;
         mm_ready   <= 1'b0;
         err        <= 1'b0;
         starve_cnt <= '0;
         tmo_cnt    <= '0;
      end else begin
         if_ready <= 1'b0;
         mm_ready <= 1'b0;
         err      <= 1'b0;
         if (start) begin
            grant_mm  <= pick_mm;
            mem_req   <= 1'b1;
            mem_we    <= pick_mm & mm_we;
            mem_addr  <= pick_mm ? mm_addr : if_addr;
            mem_wdata <= pick_mm ? mm_wdata : '0;
            tmo_cnt   <= '0;
            if (!pick_mm) begin
               starve_cnt <= '0;
            end else if (if_req && (starve_cnt < STARVE_MAX)) begin
               starve_cnt <= starve_cnt + 1'b1;
            end
         end
         if (state == BUSY) begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end
         if (ack_done || tmo_done) begin
            mem_req <= 1'b0;
            err     <= tmo_done;
            if (grant_mm) begin
               mm_rdata <= done_data;
               mm_ready <= 1'b1;
            end else begin
               if_rdata <= done_data;
               if_ready <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench with a transaction-level model of the arbiter
module tb_mem_port_arbiter;
   localparam int LIM = 4;
   localparam int TMO = 8;

   logic        clk       = 1'b0;
   logic        rst       = 1'b0;
   logic        if_req    = 1'b0;
   logic [31:0] if_addr   = '0;
   logic        mm_req    = 1'b0;
   logic        mm_we     = 1'b0;
   logic [31:0] mm_addr   = '0;
   logic [31:0] mm_wdata  = '0;
   logic        mem_ack   = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic [31:0] if_rdata, mm_rdata, mem_addr, mem_wdata;
   logic        if_ready, if_busy, mm_ready, mm_busy, err, mem_req, mem_we;

   always #5 clk = ~clk;

   mem_port_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(LIM), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready), .if_busy(if_busy),
      .mm_req(mm_req), .mm_we(mm_we), .mm_addr(mm_addr), .mm_wdata(mm_wdata),
      .mm_rdata(mm_rdata), .mm_ready(mm_ready), .mm_busy(mm_busy), .err(err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // requester queues, grant log and completion log
   logic [31:0] if_q[$];
   logic        mmq_we[$];
   logic [31:0] mmq_addr[$];
   logic [31:0] mmq_wdata[$];
   logic [31:0] g_addr[$];
   logic [31:0] g_wdata[$];
   logic        g_we[$];
   int          g_busy[$];
   int          g_gap[$];
   int          c_who[$];
   logic [31:0] c_data[$];
   logic        c_err[$];

   int          resp_delay = 0;
   logic [31:0] resp_data  = '0;
   int          stale_req  = 0;
   int          stale_done = 0;

   // memory responder: ack resp_delay cycles into the transaction, -1 never acks
   initial begin
      int  r_cnt = 0;
      logic r_acked = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         mem_ack   = 1'b0;
         mem_rdata = 32'h0BAD_0BAD;
         if (stale_req != stale_done) begin
            stale_done++;
            mem_ack   = 1'b1;
            mem_rdata = resp_data;
         end else if (mem_req && !r_acked) begin
            if (resp_delay >= 0 && r_cnt == resp_delay) begin
               mem_ack   = 1'b1;
               mem_rdata = resp_data;
               r_acked   = 1'b1;
            end else begin
               r_cnt++;
            end
         end else if (!mem_req) begin
            r_cnt   = 0;
            r_acked = 1'b0;
         end
      end
   end

   // requester drivers: hold each request until its ready, then present the next one
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (!rst) begin
            if_q.delete();
            if_req = 1'b0;
         end else begin
            if (if_req && if_ready) void'(if_q.pop_front());
            if (if_q.size() > 0) begin
               if_req  = 1'b1;
               if_addr = if_q[0];
            end else begin
               if_req = 1'b0;
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (!rst) begin
            mmq_we.delete();
            mmq_addr.delete();
            mmq_wdata.delete();
            mm_req = 1'b0;
         end else begin
            if (mm_req && mm_ready) begin
               void'(mmq_we.pop_front());
               void'(mmq_addr.pop_front());
               void'(mmq_wdata.pop_front());
            end
            if (mmq_addr.size() > 0) begin
               mm_req   = 1'b1;
               mm_we    = mmq_we[0];
               mm_addr  = mmq_addr[0];
               mm_wdata = mmq_wdata[0];
            end else begin
               mm_req = 1'b0;
            end
         end
      end
   end

   // transaction-level model
   logic        m_act = 1'b0, m_pulse = 1'b0, m_perr = 1'b0, m_who_mm = 1'b0, m_we = 1'b0;
   logic [31:0] m_addr = '0, m_wdata = '0, m_if_rd = '0, m_mm_rd = '0;
   int          m_wait = 0, m_starve = 0;

   task model_reset();
      m_act = 1'b0; m_pulse = 1'b0; m_perr = 1'b0;
      m_if_rd = '0; m_mm_rd = '0; m_starve = 0; m_wait = 0;
   endtask

   task model_finish(input logic [31:0] d, input logic e);
      m_act   = 1'b0;
      m_pulse = 1'b1;
      m_perr  = e;
      if (m_who_mm) m_mm_rd = d;
      else          m_if_rd = d;
   endtask

   task model_step();
      logic mm_wins;
      if (!rst) begin
         model_reset();
      end else if (m_pulse) begin
         m_pulse = 1'b0;
      end else if (m_act) begin
         m_wait++;
         if (mem_ack)            model_finish(mem_rdata, 1'b0);
         else if (m_wait >= TMO) model_finish('0, 1'b1);
      end else if (if_req || mm_req) begin
         mm_wins = mm_req && !(if_req && m_starve >= LIM);
         if (!mm_wins)                   m_starve = 0;
         else if (if_req && m_starve < LIM) m_starve++;
         m_act    = 1'b1;
         m_wait   = 0;
         m_who_mm = mm_wins;
         m_addr   = mm_wins ? mm_addr : if_addr;
         m_we     = mm_wins && mm_we;
         m_wdata  = mm_wdata;
      end
   endtask

   task compare();
      logic e_ifr, e_mmr;
      e_ifr = m_pulse && !m_who_mm;
      e_mmr = m_pulse && m_who_mm;
      chk("mem_req", 64'(mem_req), 64'(m_act));
      if (m_act) begin
         chk("mem_addr", 64'(mem_addr), 64'(m_addr));
         chk("mem_we", 64'(mem_we), 64'(m_we));
         if (m_we) chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
      end
      chk("if_ready", 64'(if_ready), 64'(e_ifr));
      chk("mm_ready", 64'(mm_ready), 64'(e_mmr));
      chk("err", 64'(err), 64'(m_pulse && m_perr));
      chk("if_rdata", 64'(if_rdata), 64'(m_if_rd));
      chk("mm_rdata", 64'(mm_rdata), 64'(m_mm_rd));
      chk("if_busy", 64'(if_busy), 64'(if_req && !e_ifr));
      chk("mm_busy", 64'(mm_busy), 64'(mm_req && !e_mmr));
   endtask

   logic mon_prev = 1'b0;
   int   mon_low  = 0;

   task monitor();
      if (mem_req) begin
         if (!mon_prev) begin
            g_addr.push_back(mem_addr);
            g_we.push_back(mem_we);
            g_wdata.push_back(mem_wdata);
            g_gap.push_back(mon_low);
            g_busy.push_back(0);
         end
         g_busy[g_busy.size()-1]++;
         mon_low = 0;
      end else begin
         mon_low++;
      end
      mon_prev = mem_req;
      if (if_ready) begin c_who.push_back(0); c_data.push_back(if_rdata); c_err.push_back(err); end
      if (mm_ready) begin c_who.push_back(1); c_data.push_back(mm_rdata); c_err.push_back(err); end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
         @(negedge clk);
         if (!rst) model_reset();
         compare();
         monitor();
      end
   end

   task tick();
      @(posedge clk);
      #1;
   endtask

   task push_mm(input logic we, input logic [31:0] a, input logic [31:0] d);
      mmq_we.push_back(we);
      mmq_addr.push_back(a);
      mmq_wdata.push_back(d);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((if_q.size() != 0 || mmq_addr.size() != 0 || if_req || mm_req) && n < 400) begin
         tick();
         n++;
      end
      chk(name, 64'(n < 400), 64'd1);
      repeat (3) tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int b, cb, n;
      repeat (3) tick();
      chk("rst_mem_req", 64'(mem_req), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      chk("rst_if_rdata", 64'(if_rdata), 64'd0);
      chk("rst_mm_ready", 64'(mm_ready), 64'd0);
      rst = 1'b1;
      tick();

      // single fetch, ack in the fourth BUSY cycle
      resp_delay = 3; resp_data = 32'hDEAD_BEEF;
      b = g_addr.size(); cb = c_who.size();
      if_q.push_back(32'h100);
      wait_idle("t1_idle");
      chk("t1_addr", 64'(g_addr[b]), 64'h100);
      chk("t1_we", 64'(g_we[b]), 64'd0);
      chk("t1_busy_cycles", 64'(g_busy[b]), 64'd4);
      chk("t1_who", 64'(c_who[cb]), 64'd0);
      chk("t1_rdata", 64'(c_data[cb]), 64'hDEAD_BEEF);
      chk("t1_rdata_held", 64'(if_rdata), 64'hDEAD_BEEF);

      // simultaneous requests: memory-stage write first, then fetch
      resp_delay = 0; resp_data = 32'h1111_1111;
      b = g_addr.size(); cb = c_who.size();
      push_mm(1'b1, 32'h40, 32'h5);
      if_q.push_back(32'h200);
      wait_idle("t2_idle");
      chk("t2_first_addr", 64'(g_addr[b]), 64'h40);
      chk("t2_first_we", 64'(g_we[b]), 64'd1);
      chk("t2_first_wdata", 64'(g_wdata[b]), 64'h5);
      chk("t2_first_busy", 64'(g_busy[b]), 64'd1);
      chk("t2_second_addr", 64'(g_addr[b+1]), 64'h200);
      chk("t2_second_we", 64'(g_we[b+1]), 64'd0);
      chk("t2_gap", 64'(g_gap[b+1]), 64'd2);
      chk("t2_order_mm", 64'(c_who[cb]), 64'd1);
      chk("t2_order_if", 64'(c_who[cb+1]), 64'd0);

      // starvation: fetch wins after four lost conflicts; second round shows the counter cleared
      resp_data = 32'h2222_2222;
      for (int r = 0; r < 2; r++) begin
         b = g_addr.size();
         for (int i = 0; i < 6; i++) push_mm(1'b0, 32'h300 + 32'(64*r) + 32'(4*i), 32'h0);
         if_q.push_back(32'h500 + 32'(4*r));
         wait_idle($sformatf("t3_idle_r%0d", r));
         for (int i = 0; i < 4; i++)
            chk($sformatf("t3_r%0d_mm%0d", r, i), 64'(g_addr[b+i]), 64'(32'h300 + 32'(64*r) + 32'(4*i)));
         chk($sformatf("t3_r%0d_fetch", r), 64'(g_addr[b+4]), 64'(32'h500 + 32'(4*r)));
         chk($sformatf("t3_r%0d_after", r), 64'(g_addr[b+5]), 64'(32'h310 + 32'(64*r)));
      end

      // timeout: no ack ever arrives
      resp_delay = -1;
      b = g_addr.size(); cb = c_who.size();
      push_mm(1'b0, 32'h80, 32'h0);
      wait_idle("t4_idle");
      chk("t4_busy_cycles", 64'(g_busy[b]), 64'd8);
      chk("t4_who", 64'(c_who[cb]), 64'd1);
      chk("t4_err", 64'(c_err[cb]), 64'd1);
      chk("t4_rdata", 64'(c_data[cb]), 64'd0);
      resp_delay = 0; resp_data = 32'h3333_3333;
      push_mm(1'b0, 32'h84, 32'h0);
      wait_idle("t4b_idle");
      chk("t4b_err", 64'(c_err[cb+1]), 64'd0);
      chk("t4b_rdata", 64'(c_data[cb+1]), 64'h3333_3333);

      // reset in the middle of a transaction, then a stale ack
      resp_delay = 6;
      if_q.push_back(32'h700);
      n = 0;
      while (!mem_req && n < 20) begin tick(); n++; end
      chk("t5_req_seen", 64'(mem_req), 64'd1);
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("t5_req_drop", 64'(mem_req), 64'd0);
      chk("t5_mm_rdata_clr", 64'(mm_rdata), 64'd0);
      tick(); tick();
      rst = 1'b1;
      cb = c_who.size();
      stale_req++;
      repeat (5) tick();
      chk("t5_stale_ack", 64'(c_who.size()), 64'(cb));

      // back-to-back fetches with if_req held through ready
      resp_delay = 1; resp_data = 32'h4444_4444;
      b = g_addr.size();
      if_q.push_back(32'h100);
      if_q.push_back(32'h104);
      wait_idle("t6_idle");
      chk("t6_count", 64'(g_addr.size() - b), 64'd2);
      chk("t6_first", 64'(g_addr[b]), 64'h100);
      chk("t6_second", 64'(g_addr[b+1]), 64'h104);
      chk("t6_gap", 64'(g_gap[b+1]), 64'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
